// File: rtl/instruction_fetch_queue_pkg.sv
// Shared widths, reset address and entry layout for the instruction fetch queue.
package instruction_fetch_queue_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instruction;
        logic [PC_WIDTH-1:0]    pc_plus_four;
    } fetch_entry_t;

    // Fetch addresses are word aligned; the low two bits of a branch target are discarded.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Memory request/response, redirect and decode-side handshake bundle for the fetch queue.
interface instruction_fetch_queue_if;
    import instruction_fetch_queue_pkg::*;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_req_addr;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instruction;
    logic [PC_WIDTH-1:0]    out_pc_plus_four;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc_plus_four,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc_plus_four,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// Small circular FIFO with synchronous clear; head is read combinationally from registered storage.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage is zeroed on reset so an empty queue presents an all-zero head.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = storage[rd_ptr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the PC, issues in-order reads, buffers returned words for decode
// and discards responses that belong to a fetch stream abandoned by a branch redirect.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clock,
    input  logic                       reset,
    instruction_fetch_queue_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] tag_head;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    drop;
    logic [CNT_W:0]      occupancy;
    logic                req_fire;
    logic                out_fire;
    logic                resp_keep;
    fetch_entry_t        data_head;

    // Buffered plus outstanding words are capped at DEPTH, so a kept response always has room.
    assign occupancy          = {1'b0, count} + {1'b0, inflight};
    assign bus.imem_req_valid = reset & ~bus.redirect_valid & (occupancy < (CNT_W+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

    assign bus.out_valid        = (count != '0);
    assign bus.out_instruction  = data_head.instruction;
    assign bus.out_pc_plus_four = data_head.pc_plus_four;
    assign out_fire             = bus.out_valid & bus.out_ready;

    assign resp_keep = bus.imem_resp_valid & (drop == '0) & ~bus.redirect_valid;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) data_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (resp_keep),
        .push_data ({bus.imem_resp_data, tag_head}),
        .pop       (out_fire),
        .clear     (bus.redirect_valid),
        .count     (count),
        .head      (data_head)
    );

    // The tag queue is never cleared: every outstanding request still owes a response.
    fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (DEPTH)
    ) tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (req_fire),
        .push_data (fetch_pc + 32'd4),
        .pop       (bus.imem_resp_valid),
        .clear     (1'b0),
        .count     (inflight),
        .head      (tag_head)
    );

    // A redirect marks everything still outstanding as stale, minus a response consumed this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= align_pc(bus.redirect_pc);
            drop     <= bus.imem_resp_valid ? inflight - 1'b1 : inflight;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (bus.imem_resp_valid && (drop != '0)) begin
                drop <= drop - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for the fetch queue: epoch-tagged memory model and expected output stream.
module tb_instruction_fetch_queue;
    import instruction_fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    word_t       model_q[$];
    pend_t       pending[$];
    logic [31:0] out_log[$];
    logic [31:0] model_pc;
    int          epoch;
    int          cycle;
    int          latency;
    int          req_count;
    int          checks;
    int          errors;

    always #5 clock = ~clock;

    instruction_fetch_queue_if bus ();

    instruction_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Outputs are compared at the falling edge; the model then advances on the rising edge
    // and the memory presents any due response shortly after it.
    task automatic run_cycle();
        logic  exp_valid;
        logic  exp_req;
        logic  req_fire;
        logic  out_fire;
        word_t w;
        pend_t p;
        @(negedge clock);
        exp_valid = (model_q.size() != 0);
        exp_req   = ((model_q.size() + pending.size()) < DEPTH) && !bus.redirect_valid;
        check_output("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_output("out_instruction", bus.out_instruction, model_q[0].instr);
            check_output("out_pc_plus_four", bus.out_pc_plus_four, model_q[0].pc4);
        end
        check_output("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        check_output("imem_req_addr", bus.imem_req_addr, model_pc);
        req_fire = exp_req && bus.imem_req_ready;
        out_fire = exp_valid && bus.out_ready;
        if (out_fire) out_log.push_back(model_q[0].pc4);
        if (req_fire) req_count++;
        @(posedge clock);
        if (bus.redirect_valid) begin
            epoch++;
            model_q.delete();
            model_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else if (out_fire) begin
            void'(model_q.pop_front());
        end
        if (bus.imem_resp_valid) begin
            p = pending.pop_front();
            if (p.epoch == epoch) begin
                w.instr = mem_word(p.addr);
                w.pc4   = p.addr + 32'd4;
                model_q.push_back(w);
            end
        end
        if (req_fire) begin
            p.addr  = model_pc;
            p.epoch = epoch;
            p.due   = cycle + latency;
            pending.push_back(p);
            model_pc = model_pc + 32'd4;
        end
        cycle++;
        #1;
        bus.redirect_valid = 1'b0;
        if (pending.size() > 0 && pending[0].due <= cycle) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pending[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
    endtask

    task automatic apply_stimulus(input logic req_ready, input logic out_ready,
                                  input logic redirect, input logic [31:0] target);
        bus.imem_req_ready = req_ready;
        bus.out_ready      = out_ready;
        bus.redirect_valid = redirect;
        bus.redirect_pc    = target;
        run_cycle();
    endtask

    // Asserts reset between edges and checks the outputs settle without a clock edge.
    task automatic do_reset();
        reset               = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.out_ready       = 1'b0;
        model_q.delete();
        pending.delete();
        model_pc = 32'h0;
        #1;
        check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_output("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check_output("rst_req_addr", bus.imem_req_addr, 32'h0);
        check_output("rst_out_instruction", bus.out_instruction, 32'h0);
        check_output("rst_out_pc_plus_four", bus.out_pc_plus_four, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic wait_for_out(input string name, input int max_cycles, input logic [31:0] expected);
        for (int i = 0; i < max_cycles && out_log.size() == 0; i++) begin
            run_cycle();
        end
        if (out_log.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: no word consumed within %0d cycles, expected pc+4 %h", name, max_cycles, expected);
        end else begin
            check_output(name, out_log[0], expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        epoch     = 0;
        cycle     = 0;
        latency   = 1;
        req_count = 0;
        #2;

        // Streaming with a one-cycle memory and decode always ready.
        do_reset();
        check_output("t1_first_addr", bus.imem_req_addr, 32'h0);
        out_log.delete();
        repeat (8) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        if (out_log.size() < 3) begin
            checks++;
            errors++;
            $display("[TB] FAIL t1_stream: got %0d words, expected at least 3", out_log.size());
        end else begin
            check_output("t1_pc4_0", out_log[0], 32'h4);
            check_output("t1_pc4_1", out_log[1], 32'h8);
            check_output("t1_pc4_2", out_log[2], 32'hC);
        end

        // Decode stalled: the credit cap stops fetch after DEPTH requests.
        do_reset();
        req_count = 0;
        repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t2_req_count", 32'(req_count), 32'd4);
        check_output("t2_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check_output("t2_head_pc4", bus.out_pc_plus_four, 32'h4);
        check_output("t2_head_instr", bus.out_instruction, 32'h1357_9BDF);
        repeat (8) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect with three requests outstanding on a three-cycle memory.
        do_reset();
        latency = 3;
        repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h100);
        out_log.delete();
        wait_for_out("t3_first_after_redirect", 30, 32'h104);

        // Redirect coinciding with a response and a consumed head.
        do_reset();
        latency = 1;
        repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check_output("t4_pre_out_valid", 32'(bus.out_valid), 32'h1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h203);
        check_output("t4_post_out_valid", 32'(bus.out_valid), 32'h0);
        out_log.delete();
        wait_for_out("t4_first_after_redirect", 20, 32'h204);

        // Back-to-back redirects: nothing from the first target may reach decode.
        do_reset();
        latency = 3;
        repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h40);
        out_log.delete();
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80);
        wait_for_out("t5_first_after_redirects", 30, 32'h84);

        // Irregular memory acceptance and decode backpressure with a redirect mid-stream.
        latency = 2;
        for (int i = 0; i < 40; i++) begin
            apply_stimulus((i % 3) != 0, (i % 5) < 3, i == 17, 32'h1000);
        end

        // Reset in the middle of traffic with three buffered and one outstanding.
        do_reset();
        latency = 1;
        repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t6_pre_out_valid", 32'(bus.out_valid), 32'h1);
        #2;
        do_reset();
        out_log.delete();
        repeat (6) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check_output("t6_restart_pc4", (out_log.size() > 0) ? out_log[0] : 32'hFFFF_FFFF, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
